// File: rtl/output_capture_pkg.sv
// Shared types and widths for the output capture block.
package output_capture_pkg;

  localparam int unsigned DATA_WIDTH = 36;
  localparam int unsigned BX_WIDTH   = 3;
  localparam int unsigned EVT_WIDTH  = 16;
  localparam int unsigned NUM_WIDTH  = 7;
  localparam int unsigned FIFO_DEPTH = 64;

  // Field order matches the .dat line format: bx, event, num, data
  typedef struct packed {
    logic                  stream;
    logic [BX_WIDTH-1:0]   bx;
    logic [EVT_WIDTH-1:0]  evt;
    logic [NUM_WIDTH-1:0]  num;
    logic [DATA_WIDTH-1:0] data;
  } cap_rec_t;

  localparam int unsigned REC_WIDTH = $bits(cap_rec_t);

  // Idle fill value written by the upstream memories
  localparam logic [DATA_WIDTH-1:0] IDLE_ZERO = '0;

  // Per-event word index: counts up and sticks at all-ones
  function automatic logic [NUM_WIDTH-1:0] num_sat_inc(input logic [NUM_WIDTH-1:0] n);
    return (n == '1) ? n : n + NUM_WIDTH'(1);
  endfunction

endpackage

// File: rtl/output_capture_if.sv
// Write streams, event strobe, readout port and overflow flags of output_capture.
interface output_capture_if;
  import output_capture_pkg::*;

  logic                  BC0;
  logic                  out_1_valid;
  logic [DATA_WIDTH-1:0] out_1_data;
  logic                  out_2_valid;
  logic [DATA_WIDTH-1:0] out_2_data;
  logic                  rec_valid;
  logic                  rec_ready;
  logic                  rec_stream;
  logic [BX_WIDTH-1:0]   rec_bx;
  logic [EVT_WIDTH-1:0]  rec_event;
  logic [NUM_WIDTH-1:0]  rec_num;
  logic [DATA_WIDTH-1:0] rec_data;
  logic                  overflow_1;
  logic                  overflow_2;

  modport master (
    output BC0, out_1_valid, out_1_data, out_2_valid, out_2_data, rec_ready,
    input  rec_valid, rec_stream, rec_bx, rec_event, rec_num, rec_data,
    input  overflow_1, overflow_2
  );

  modport slave (
    input  BC0, out_1_valid, out_1_data, out_2_valid, out_2_data, rec_ready,
    output rec_valid, rec_stream, rec_bx, rec_event, rec_num, rec_data,
    output overflow_1, overflow_2
  );

endinterface

// File: rtl/output_capture_fifo.sv
// capture_fifo: single-clock record FIFO with registered empty/full/two flags.
// Exposes the head entry and the one behind it so the reader can pop and
// present the following record in the same cycle.
module capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] next_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             two_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_nxt;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             two_q, two_d;
  logic             do_push, do_pop;

  // Pointer/count update; full is taken from the register, before any pop
  always_comb begin
    do_push  = push_i && !full_q;
    do_pop   = pop_i && !empty_q;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    empty_d  = (cnt_d == '0);
    full_d   = (cnt_d == CW'(DEPTH));
    two_d    = (cnt_d >= CW'(2));
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      two_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      two_q    <= two_d;
    end
  end

  // Storage array, written at the accepting edge
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rd_nxt  = rd_ptr_q + AW'(1);
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_nxt];
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign two_o   = two_q;

endmodule

// File: rtl/output_capture.sv
// output_capture: stamps two output-memory write streams with bx/event/num,
// buffers them per stream and drains them through one round-robin readout.
// Optional build macro OUTPUT_CAPTURE_ZERO_SUPPRESS_EN: all-zero (idle) words
// are ignored entirely (not stored, not counted, no overflow).
// The output register is a copy of the granted FIFO head; the FIFO entry is
// only popped on handshake, so a stream holds exactly FIFO_DEPTH records.
module output_capture
  import output_capture_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  output_capture_if.slave bus
);

  logic [BX_WIDTH-1:0]  bx_q, bx_d, stamp_bx;
  logic [EVT_WIDTH-1:0] evt_q, evt_d, stamp_evt;
  logic [NUM_WIDTH-1:0] num1_q, num1_d, stamp_num1;
  logic [NUM_WIDTH-1:0] num2_q, num2_d, stamp_num2;
  logic                 ovf1_q, ovf1_d, ovf2_q, ovf2_d;
  logic                 seen1, seen2, push1, push2, pop1, pop2;
  logic                 full1, full2, empty1, empty2, two1, two2;
  cap_rec_t             wrec1, wrec2, head1, head2, next1, next2, cand1, cand2;
  cap_rec_t             out_rec_q, out_rec_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ptr_q, ptr_d, ptr_eff;
  logic                 hs, avail1, avail2, load, grant;

`ifdef OUTPUT_CAPTURE_ZERO_SUPPRESS_EN
  assign seen1 = bus.out_1_valid && (bus.out_1_data != IDLE_ZERO);
  assign seen2 = bus.out_2_valid && (bus.out_2_data != IDLE_ZERO);
`else
  assign seen1 = bus.out_1_valid;
  assign seen2 = bus.out_2_valid;
`endif

  // Event counters and stamping; a BC0-cycle word sees the new bx/event and num 0
  always_comb begin
    stamp_bx   = bx_q;
    stamp_evt  = evt_q;
    stamp_num1 = num1_q;
    stamp_num2 = num2_q;
    if (bus.BC0) begin
      stamp_bx   = bx_q + BX_WIDTH'(1);
      stamp_evt  = evt_q + EVT_WIDTH'(1);
      stamp_num1 = '0;
      stamp_num2 = '0;
    end
    bx_d   = stamp_bx;
    evt_d  = stamp_evt;
    num1_d = seen1 ? num_sat_inc(stamp_num1) : stamp_num1;
    num2_d = seen2 ? num_sat_inc(stamp_num2) : stamp_num2;
    push1  = seen1 && !full1;
    push2  = seen2 && !full2;
    ovf1_d = ovf1_q || (seen1 && full1);
    ovf2_d = ovf2_q || (seen2 && full2);
    wrec1  = '{stream: 1'b0, bx: stamp_bx, evt: stamp_evt, num: stamp_num1, data: bus.out_1_data};
    wrec2  = '{stream: 1'b1, bx: stamp_bx, evt: stamp_evt, num: stamp_num2, data: bus.out_2_data};
  end

  capture_fifo #(.WIDTH(REC_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push1),
    .wdata_i (wrec1),
    .pop_i   (pop1),
    .head_o  (head1),
    .next_o  (next1),
    .empty_o (empty1),
    .full_o  (full1),
    .two_o   (two1)
  );

  capture_fifo #(.WIDTH(REC_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_2 (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push2),
    .wdata_i (wrec2),
    .pop_i   (pop2),
    .head_o  (head2),
    .next_o  (next2),
    .empty_o (empty2),
    .full_o  (full2),
    .two_o   (two2)
  );

  // Round-robin grant and output register load; arbitration sees the pointer
  // as already toggled by a handshake in this cycle
  always_comb begin
    hs          = out_valid_q && bus.rec_ready;
    ptr_eff     = ptr_q ^ hs;
    ptr_d       = ptr_eff;
    pop1        = hs && !out_rec_q.stream;
    pop2        = hs && out_rec_q.stream;
    avail1      = pop1 ? two1 : !empty1;
    avail2      = pop2 ? two2 : !empty2;
    cand1       = pop1 ? next1 : head1;
    cand2       = pop2 ? next2 : head2;
    load        = !out_valid_q || hs;
    grant       = avail2 && (!avail1 || ptr_eff);
    out_valid_d = out_valid_q;
    out_rec_d   = out_rec_q;
    if (load) begin
      out_valid_d = avail1 || avail2;
      if (avail1 || avail2) begin
        out_rec_d = grant ? cand2 : cand1;
      end
    end
  end

  // Counter, flag, pointer and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bx_q        <= '0;
      evt_q       <= '0;
      num1_q      <= '0;
      num2_q      <= '0;
      ovf1_q      <= 1'b0;
      ovf2_q      <= 1'b0;
      ptr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_rec_q   <= '0;
    end else begin
      bx_q        <= bx_d;
      evt_q       <= evt_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      ovf1_q      <= ovf1_d;
      ovf2_q      <= ovf2_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_rec_q   <= out_rec_d;
    end
  end

  assign bus.rec_valid  = out_valid_q;
  assign bus.rec_stream = out_rec_q.stream;
  assign bus.rec_bx     = out_rec_q.bx;
  assign bus.rec_event  = out_rec_q.evt;
  assign bus.rec_num    = out_rec_q.num;
  assign bus.rec_data   = out_rec_q.data;
  assign bus.overflow_1 = ovf1_q;
  assign bus.overflow_2 = ovf2_q;

endmodule

// File: tb/tb_output_capture.sv
// Self-checking bench for output_capture against a per-stream queue model.
module tb_output_capture;
  import output_capture_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  output_capture_if bus ();

  output_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state
  int       m_bx, m_evt;
  int       m_num [2];
  int       acc [2];
  int       cons_base [2];
  bit       m_ovf [2];
  cap_rec_t exp_q0 [$];
  cap_rec_t exp_q1 [$];

  // Observed handshakes (written only by the monitor)
  cap_rec_t obs_q [$];
  int       cons [2];
  int       obs_rd = 0;

  always @(negedge clk) begin
    if (!reset && bus.rec_valid && bus.rec_ready) begin
      cap_rec_t r;
      r.stream = bus.rec_stream;
      r.bx     = bus.rec_bx;
      r.evt    = bus.rec_event;
      r.num    = bus.rec_num;
      r.data   = bus.rec_data;
      obs_q.push_back(r);
      cons[int'(r.stream)] = cons[int'(r.stream)] + 1;
    end
  end

  task automatic model_clear();
    m_bx = 0; m_evt = 0;
    for (int k = 0; k < 2; k++) begin
      m_num[k] = 0; acc[k] = 0; m_ovf[k] = 1'b0; cons_base[k] = cons[k];
    end
    exp_q0.delete(); exp_q1.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic model_word(input int k, input logic v, input logic [DATA_WIDTH-1:0] d);
    cap_rec_t r;
    if (!v) return;
`ifdef OUTPUT_CAPTURE_ZERO_SUPPRESS_EN
    if (d == '0) return;
`endif
    if (acc[k] - (cons[k] - cons_base[k]) >= int'(FIFO_DEPTH)) begin
      m_ovf[k] = 1'b1;
    end else begin
      r.stream = (k == 1);
      r.bx     = BX_WIDTH'(m_bx);
      r.evt    = EVT_WIDTH'(m_evt);
      r.num    = NUM_WIDTH'(m_num[k]);
      r.data   = d;
      if (k == 0) exp_q0.push_back(r); else exp_q1.push_back(r);
      acc[k] = acc[k] + 1;
    end
    m_num[k] = (m_num[k] >= 127) ? 127 : m_num[k] + 1;
  endtask

  // Drive one cycle of inputs (they take effect at the next rising edge)
  task automatic drive(input logic bc0, input logic v1, input logic [DATA_WIDTH-1:0] d1,
                       input logic v2, input logic [DATA_WIDTH-1:0] d2);
    @(posedge clk); #1;
    bus.BC0 = bc0;
    bus.out_1_valid = v1; bus.out_1_data = d1;
    bus.out_2_valid = v2; bus.out_2_data = d2;
    if (bc0) begin
      m_bx = (m_bx + 1) % 8;
      m_evt = (m_evt + 1) % 65536;
      m_num[0] = 0; m_num[1] = 0;
    end
    model_word(0, v1, d1);
    model_word(1, v2, d2);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.BC0 = 1'b0; bus.out_1_valid = 1'b0; bus.out_2_valid = 1'b0;
    bus.out_1_data = '0; bus.out_2_data = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // Wait for all modelled records, then match each one against its stream queue
  task automatic check_drain(input string name, input int budget);
    int want;
    int n;
    cap_rec_t r, e;
    want = exp_q0.size() + exp_q1.size();
    n = 0;
    while ((obs_q.size() - obs_rd) < want && n < budget) begin
      @(negedge clk); n++;
    end
    checks++;
    if ((obs_q.size() - obs_rd) < want) begin
      failures++;
      $display("FAIL %s_timeout got=%0d want=%0d", name, obs_q.size() - obs_rd, want);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ((obs_q.size() - obs_rd) != want) begin
      failures++;
      $display("FAIL %s_count got=%0d want=%0d", name, obs_q.size() - obs_rd, want);
    end
    while (obs_rd < obs_q.size()) begin
      r = obs_q[obs_rd];
      obs_rd++;
      if ((r.stream ? exp_q1.size() : exp_q0.size()) == 0) begin
        checks++; failures++;
        $display("FAIL %s_unexpected s=%0d num=%0d data=%0h", name, r.stream, r.num, r.data);
      end else begin
        e = r.stream ? exp_q1.pop_front() : exp_q0.pop_front();
        checks++;
        if (r !== e) begin
          failures++;
          $display("FAIL %s_rec got s=%0d bx=%0d evt=%0d num=%0d data=%0h want s=%0d bx=%0d evt=%0d num=%0d data=%0h",
                   name, r.stream, r.bx, r.evt, r.num, r.data, e.stream, e.bx, e.evt, e.num, e.data);
        end
      end
    end
    exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.rec_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0b want=0", bus.rec_valid);
    end
    checks++;
    if ({bus.rec_stream, bus.rec_bx, bus.rec_event, bus.rec_num, bus.rec_data} !== '0) begin
      failures++; $display("FAIL reset_fields got num=%0d data=%0h want 0", bus.rec_num, bus.rec_data);
    end
    checks++;
    if ({bus.overflow_1, bus.overflow_2} !== 2'b00) begin
      failures++; $display("FAIL reset_ovf got=%b%b want=00", bus.overflow_1, bus.overflow_2);
    end
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    bus.rec_ready = 1'b1;
    base = obs_rd;
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    drive(1'b0, 1'b1, 36'h1, 1'b0, '0);
    drive(1'b0, 1'b1, 36'h2, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (bus.rec_valid !== 1'b0) begin
      failures++; $display("FAIL basic_latency_early got=%0b want=0", bus.rec_valid);
    end
    drive(1'b0, 1'b1, 36'h3, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (bus.rec_valid !== 1'b1 || bus.rec_num !== 7'd0 || bus.rec_data !== 36'h1) begin
      failures++;
      $display("FAIL basic_latency got valid=%0b num=%0d data=%0h want 1/0/1", bus.rec_valid, bus.rec_num, bus.rec_data);
    end
    idle();
    check_drain("basic", 50);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_q.size() <= base + i) begin
        failures++; $display("FAIL basic_missing idx=%0d", i);
      end else if (obs_q[base+i].bx !== 3'd1 || obs_q[base+i].evt !== 16'd1 ||
                   obs_q[base+i].num !== NUM_WIDTH'(i) || obs_q[base+i].data !== DATA_WIDTH'(i + 1)) begin
        failures++;
        $display("FAIL basic_stamp idx=%0d got bx=%0d evt=%0d num=%0d data=%0h want 1/1/%0d/%0h",
                 i, obs_q[base+i].bx, obs_q[base+i].evt, obs_q[base+i].num, obs_q[base+i].data, i, i + 1);
      end
    end
  endtask

  task automatic test_round_robin();
    int base;
    logic [3:0] got;
    do_reset();
    bus.rec_ready = 1'b1;
    base = obs_rd;
    drive(1'b0, 1'b1, 36'hA0, 1'b1, 36'hB0);
    drive(1'b0, 1'b1, 36'hA1, 1'b1, 36'hB1);
    idle();
    check_drain("rr", 50);
    got = '1;
    for (int i = 0; i < 4; i++) begin
      if (obs_q.size() > base + i) got[i] = obs_q[base+i].stream;
    end
    checks++;
    if (got !== 4'b1010) begin
      failures++; $display("FAIL rr_order got=%b want=1010 (bit0 first)", got);
    end
  endtask

  task automatic test_overflow();
    cap_rec_t h;
    do_reset();
    bus.rec_ready = 1'b0;
    for (int i = 0; i < 64; i++) drive(1'b0, 1'b0, '0, 1'b1, DATA_WIDTH'(100 + i));
    drive(1'b0, 1'b0, '0, 1'b1, DATA_WIDTH'(164));
    @(negedge clk);
    checks++;
    if (bus.overflow_2 !== 1'b0) begin
      failures++; $display("FAIL ovf_early got=%0b want=0", bus.overflow_2);
    end
    idle();
    @(negedge clk);
    checks++;
    if (bus.overflow_2 !== m_ovf[1] || bus.overflow_2 !== 1'b1) begin
      failures++; $display("FAIL ovf_2 got=%0b want=1", bus.overflow_2);
    end
    checks++;
    if (bus.overflow_1 !== 1'b0) begin
      failures++; $display("FAIL ovf_1 got=%0b want=0", bus.overflow_1);
    end
    h = '{stream: 1'b1, bx: '0, evt: '0, num: '0, data: DATA_WIDTH'(100)};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rec_valid !== 1'b1 || {bus.rec_stream, bus.rec_bx, bus.rec_event, bus.rec_num, bus.rec_data} !== h) begin
        failures++;
        $display("FAIL ovf_hold got valid=%0b s=%0d num=%0d data=%0h want 1/1/0/64", bus.rec_valid, bus.rec_stream, bus.rec_num, bus.rec_data);
      end
    end
    checks++;
    if (exp_q1.size() != 64) begin
      failures++; $display("FAIL ovf_model_depth got=%0d want=64", exp_q1.size());
    end
    @(posedge clk); #1;
    bus.rec_ready = 1'b1;
    check_drain("ovf", 200);
  endtask

  task automatic test_mid_drain_reset();
    int base;
    bus.rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, DATA_WIDTH'(200 + i), 1'b0, '0);
    idle();
    bus.rec_ready = 1'b1;
    repeat (3) idle();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rec_valid !== 1'b0 || bus.overflow_1 !== 1'b0 || bus.overflow_2 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got valid=%0b ovf=%b%b want 0/00", bus.rec_valid, bus.overflow_1, bus.overflow_2);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    base = obs_rd;
    drive(1'b0, 1'b1, DATA_WIDTH'(7), 1'b0, '0);
    idle();
    check_drain("mid", 50);
    checks++;
    if (obs_q.size() <= base) begin
      failures++; $display("FAIL mid_first missing");
    end else if (obs_q[base].bx !== '0 || obs_q[base].evt !== '0 || obs_q[base].num !== '0 || obs_q[base].data !== DATA_WIDTH'(7)) begin
      failures++;
      $display("FAIL mid_first got bx=%0d evt=%0d num=%0d data=%0h want 0/0/0/7",
               obs_q[base].bx, obs_q[base].evt, obs_q[base].num, obs_q[base].data);
    end
  endtask

  task automatic test_bc0_wrap();
    int base;
    do_reset();
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      idle();
    end
    base = obs_rd;
    drive(1'b1, 1'b1, 36'hABC, 1'b0, '0);
    idle();
    check_drain("wrap", 50);
    checks++;
    if (obs_q.size() <= base) begin
      failures++; $display("FAIL wrap_rec missing");
    end else if (obs_q[base].bx !== 3'd0 || obs_q[base].evt !== 16'd8 || obs_q[base].num !== 7'd0) begin
      failures++;
      $display("FAIL wrap_rec got bx=%0d evt=%0d num=%0d want 0/8/0", obs_q[base].bx, obs_q[base].evt, obs_q[base].num);
    end
  endtask

  task automatic test_zero_suppress();
    int base;
    int want_n;
    do_reset();
    bus.rec_ready = 1'b1;
    base = obs_rd;
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    drive(1'b0, 1'b1, 36'h5, 1'b0, '0);
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    idle();
    check_drain("zero", 50);
`ifdef OUTPUT_CAPTURE_ZERO_SUPPRESS_EN
    want_n = 1;
    checks++;
    if (obs_q.size() > base && (obs_q[base].num !== 7'd0 || obs_q[base].data !== 36'h5)) begin
      failures++; $display("FAIL zero_rec got num=%0d data=%0h want 0/5", obs_q[base].num, obs_q[base].data);
    end
`else
    want_n = 3;
    checks++;
    if (obs_q.size() > base + 1 && (obs_q[base+1].num !== 7'd1 || obs_q[base+1].data !== 36'h5)) begin
      failures++; $display("FAIL zero_rec got num=%0d data=%0h want 1/5", obs_q[base+1].num, obs_q[base+1].data);
    end
`endif
    checks++;
    if (obs_q.size() - base != want_n) begin
      failures++; $display("FAIL zero_count got=%0d want=%0d", obs_q.size() - base, want_n);
    end
  endtask

  task automatic test_random();
    logic [DATA_WIDTH-1:0] d1, d2;
    do_reset();
    bus.rec_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      d1 = DATA_WIDTH'({4'($urandom_range(15, 0)), 32'($urandom)});
      d2 = DATA_WIDTH'({4'($urandom_range(15, 0)), 32'($urandom)});
      drive($urandom_range(15, 0) == 0, $urandom_range(1, 0) == 1, d1, $urandom_range(1, 0) == 1, d2);
      bus.rec_ready = (c > 150 && c < 250) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
    end
    idle();
    bus.rec_ready = 1'b1;
    check_drain("rand", 1000);
    checks++;
    if (bus.overflow_1 !== m_ovf[0] || bus.overflow_2 !== m_ovf[1]) begin
      failures++;
      $display("FAIL rand_ovf got=%b%b want=%b%b", bus.overflow_1, bus.overflow_2, m_ovf[0], m_ovf[1]);
    end
  endtask

  initial begin
    bus.BC0 = 1'b0; bus.out_1_valid = 1'b0; bus.out_2_valid = 1'b0;
    bus.out_1_data = '0; bus.out_2_data = '0; bus.rec_ready = 1'b0;
    for (int k = 0; k < 2; k++) cons[k] = 0;
    test_reset();
    test_basic();
    test_round_robin();
    test_overflow();
    test_mid_drain_reset();
    test_bc0_wrap();
    test_zero_suppress();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/output_capture.md
# output_capture

Synthesizable capture block at the output end of a TrackletProject processing chain. It accepts two output-memory write streams and stamps every accepted word with the current bx, the event number and its per-event word index. It buffers the records per stream and drains them through one round-robin ready/valid readout port. The record fields are bx, event, num and data, the same four fields, in that order, as the `.dat` stimulus line format, so captured output can be compared directly against emulation files.

## Interface
- `DATA_WIDTH`, 36, width of each captured data word
- `BX_WIDTH`, 3, bx counter width (wraps)
- `EVT_WIDTH`, 16, event counter width (wraps)
- `NUM_WIDTH`, 7, per-event word index width (saturates)
- `FIFO_DEPTH`, 64, records per stream FIFO, power of two
- `clk`  in  1  single clock; everything in this block runs on it
- `reset`  in  1  synchronous, active-high
- `BC0`  in  1  one-cycle event-boundary strobe
- `out_1_valid`, `out_2_valid`  in  1  stream write strobes
- `out_1_data`, `out_2_data`  in  DATA_WIDTH  stream data words
- `rec_valid`  out  1  a record is presented
- `rec_ready`  in  1  consumer accepts the record
- `rec_stream`  out  1  source stream: 0 = stream 1, 1 = stream 2
- `rec_bx`  out  BX_WIDTH  bx stamp of the record
- `rec_event`  out  EVT_WIDTH  event stamp of the record
- `rec_num`  out  NUM_WIDTH  index of the word within its event
- `rec_data`  out  DATA_WIDTH  captured data word
- `overflow_1`, `overflow_2`  out  1  sticky flag: a word was dropped on this stream

## Operation
- **Counters.** On each `BC0`: `bx` increments and wraps, `event` increments and wraps, and both per-stream `num` counters reset to 0.
- **Stamping.** A word accepted in the same cycle as `BC0` takes the new bx and event values and gets num 0.
- **Accept rule.** A word is accepted when `out_k_valid`=1 and FIFO k is not full.
  - `num_k` increments after each accepted word and saturates at all-ones.
  - Full is evaluated before any same-cycle pop. A push arriving while the FIFO is full is dropped even if a pop happens in that cycle.
- **Drop.** A dropped word sets `overflow_k`, which stays set until `reset`. `num_k` still increments on a drop, so the gap in indices is visible at readout.
- **Arbiter.** Round-robin between the two FIFOs, driven by a one-bit priority pointer.
  - If both FIFOs are non-empty, the stream named by the pointer is granted. Otherwise whichever FIFO is non-empty is granted.
  - The pointer toggles after each handshake (`rec_valid`&`rec_ready`).
- **Output hold.** The output register holds its record, with all fields stable, while `rec_valid`=1 and `rec_ready`=0.
- **Reset.** `reset` at any time, including mid-drain:
  - all FIFOs empty;
  - bx, event and num counters = 0; pointer = 0;
  - `rec_valid`=0, all `rec_*` fields = 0, overflow flags = 0.
- **Before first BC0.** Words captured before the first `BC0` after reset carry bx 0, event 0.

## Timing
- **Write.** A word accepted at edge N is written into its FIFO at edge N.
- **Read latency.** `rec_valid` rises at edge N+1 when the output stage was empty. Input-to-readout latency is 1 cycle.
- **Throughput.** One record per cycle while `rec_ready`=1.
- **Full flag.** The FIFO full flag is registered. Capacity is exactly `FIFO_DEPTH` records.
- **Overflow flag.** `overflow_k` is set at the edge where the drop occurs.

## Configuration
- Macro: `OUTPUT_CAPTURE_ZERO_SUPPRESS_EN`.
- **Defined:** a valid word whose data is all zeros (the idle fill value) is neither stored nor counted: `num` is unchanged and the overflow flag is not set for it.
- **Undefined:** all-zero words are captured like any other word.

## Structure
- **Package `output_capture_pkg`:**
  - record typedef `{stream, bx, event, num, data}`;
  - width localparams;
  - the idle-zero constant.
- **Sub-module `capture_fifo`:** synchronous single-clock FIFO with registered full/empty flags, instantiated once per stream.
- **Top level:** the counters, the stamping logic, the arbiter and the output register.

## Test plan
- **Basic stamping:** reset, then `BC0`, then 3 words on stream 1 (`36'h1`, `36'h2`, `36'h3`) with `rec_ready`=1. Expect records bx=1, evt=1, num 0/1/2 in order; first `rec_valid` one cycle after the first write.
- **Round-robin:** both streams write 2 words each in the same cycles with `rec_ready`=1. Expect output order s1, s2, s1, s2.
- **Overflow:** `rec_ready`=0, 65 words on stream 2. Expect 64 stored, `overflow_2`=1, `overflow_1`=0. Then `rec_ready`=1 drains nums 0..63.
- **BC0 collision and wrap:** a word written in the same cycle as the 8th `BC0`. Expect bx=0 (wrapped), evt=8, num=0.
- **Mid-drain reset:** `reset` asserted while draining 10 buffered records. Next cycle `rec_valid`=0, overflow flags 0; the next word captured gets bx=0, evt=0, num=0.
- **Zero suppression:** with `OUTPUT_CAPTURE_ZERO_SUPPRESS_EN`, stream 1 writes 0, `36'h5`, 0. Expect a single record, num=0, data=`36'h5`. Without the macro, expect 3 records.
